sdram_arbiter: RTL and testbench

Wishbone arbiter that shares the single SDRAM controller port among several chipset requesters: video/cursor DMA, sound DMA and the CPU. It sits between those masters and the SDRAM controller's wishbone slave in the `wb_clk` domain. It holds a grant for the full `wb_cyc` of the winning master, including the two-beat incrementing burst (`cti=3'b010`). A watchdog aborts a cycle the controller never acknowledges.

---
 rtl/sdram_arb_pkg.sv | 13 +
 rtl/sdram_arb_pick.sv | 47 ++++
 rtl/sdram_arbiter.sv | 154 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM wishbone arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_ABORT
  } arb_state_e;

  localparam int unsigned ARB_TIMEOUT_DEF = 255;
  localparam logic [2:0]  CTI_INCR        = 3'b010;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational one-hot winner select. SDRAM_ARB_RR_EN selects round-robin
// starting after the last owner; otherwise the lowest requesting index wins.
module sdram_arb_pick #(
  parameter int unsigned NUM_M = 3
`ifdef SDRAM_ARB_RR_EN
  , parameter int unsigned IDX_W = 2
`endif
) (
  input  logic [NUM_M-1:0] i_req,
`ifdef SDRAM_ARB_RR_EN
  input  logic [IDX_W-1:0] i_last,
`endif
  output logic [NUM_M-1:0] o_gnt
);

  logic w_found;

`ifdef SDRAM_ARB_RR_EN
  int unsigned w_pos;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int unsigned k = 1; k <= NUM_M; k++) begin
      w_pos = int'(i_last) + k;
      if (w_pos >= NUM_M) w_pos = w_pos - NUM_M;
      if (!w_found && i_req[w_pos]) begin
        o_gnt[w_pos] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end
`else
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      if (!w_found && i_req[k]) begin
        o_gnt[k] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// Wishbone arbiter sharing the SDRAM controller port among NUM_M masters, with
// an ack watchdog. Define SDRAM_ARB_RR_EN for round-robin instead of fixed priority.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_M   = 3,
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEF
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst_n,
  input  logic [NUM_M-1:0]        m_cyc,
  input  logic [NUM_M-1:0]        m_stb,
  input  logic [NUM_M-1:0]        m_we,
  input  logic [NUM_M*ADDR_W-1:0] m_adr,
  input  logic [NUM_M*32-1:0]     m_dat_i,
  input  logic [NUM_M*4-1:0]      m_sel,
  input  logic [NUM_M*3-1:0]      m_cti,
  output logic [NUM_M-1:0]        m_ack,
  output logic [NUM_M-1:0]        m_err,
  output logic [31:0]             m_dat_o,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [ADDR_W-1:0]       s_adr,
  output logic [31:0]             s_dat_o,
  output logic [3:0]              s_sel,
  output logic [2:0]              s_cti,
  input  logic [31:0]             s_dat_i,
  input  logic                    s_ack,
  output logic [NUM_M-1:0]        grant
);

  arb_state_e       r_state, w_nstate;
  logic [NUM_M-1:0] r_grant, r_err, w_req, w_pick;
  logic [7:0]       r_wdt;
  logic             w_own_cyc, w_expire;

  assign w_req     = m_cyc & m_stb;
  assign w_own_cyc = |(m_cyc & r_grant);
  // An ack in the final watchdog cycle keeps the owner in BUSY.
  assign w_expire  = (r_state == ARB_BUSY) && w_own_cyc && !s_ack &&
                     (r_wdt == 8'(TIMEOUT - 1));

`ifdef SDRAM_ARB_RR_EN
  localparam int unsigned IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  logic [IDX_W-1:0] r_last, w_pick_idx;

  always_comb begin
    w_pick_idx = '0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      if (w_pick[k]) w_pick_idx = IDX_W'(k);
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_last <= IDX_W'(NUM_M - 1);
    end else if (r_state == ARB_IDLE && |w_req) begin
      r_last <= w_pick_idx;
    end
  end

  sdram_arb_pick #(
    .NUM_M (NUM_M),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_pick)
  );
`else
  sdram_arb_pick #(
    .NUM_M (NUM_M)
  ) u_pick (
    .i_req (w_req),
    .o_gnt (w_pick)
  );
`endif

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) r_state <= ARB_IDLE;
    else           r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      ARB_IDLE:  if (|w_req) w_nstate = ARB_BUSY;
      ARB_BUSY:  begin
        if (!w_own_cyc)    w_nstate = ARB_IDLE;
        else if (w_expire) w_nstate = ARB_ABORT;
      end
      ARB_ABORT: if (!w_own_cyc) w_nstate = ARB_IDLE;
      default:   w_nstate = ARB_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_grant <= '0;
      r_wdt   <= '0;
      r_err   <= '0;
    end else begin
      r_err <= w_expire ? r_grant : '0;
      case (r_state)
        ARB_IDLE: begin
          if (|w_req) begin
            r_grant <= w_pick;
            r_wdt   <= '0;
          end
        end
        ARB_BUSY: begin
          if (!w_own_cyc) r_grant <= '0;
          else if (s_ack) r_wdt   <= '0;
          else            r_wdt   <= r_wdt + 8'd1;
        end
        ARB_ABORT: if (!w_own_cyc) r_grant <= '0;
        default:   r_grant <= '0;
      endcase
    end
  end

  // Slave side is a pure mux of the registered grant so the ack path stays combinational.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_o = '0;
    s_sel   = '0;
    s_cti   = '0;
    m_ack   = '0;
    if (r_state == ARB_BUSY) begin
      for (int unsigned k = 0; k < NUM_M; k++) begin
        if (r_grant[k]) begin
          s_cyc   = m_cyc[k];
          s_stb   = m_stb[k];
          s_we    = m_we[k];
          s_adr   = m_adr[k*ADDR_W +: ADDR_W];
          s_dat_o = m_dat_i[k*32 +: 32];
          s_sel   = m_sel[k*4 +: 4];
          s_cti   = m_cti[k*3 +: 3];
        end
      end
      m_ack = r_grant & {NUM_M{s_ack}};
    end
  end

  assign m_err   = r_err;
  assign m_dat_o = s_dat_i;
  assign grant   = r_grant;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: masters and slave are behavioural, a
// transaction-level model predicts service order and response for each batch.
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  localparam int NUM_M  = 3;
  localparam int ADDR_W = 24;
  localparam int TMO    = 16;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_M-1:0]        m_cyc = '0, m_stb = '0, m_we = '0;
  logic [NUM_M*ADDR_W-1:0] m_adr = '0;
  logic [NUM_M*32-1:0]     m_dat_i = '0;
  logic [NUM_M*4-1:0]      m_sel = '0;
  logic [NUM_M*3-1:0]      m_cti = '0;
  logic [NUM_M-1:0]        m_ack, m_err, grant;
  logic [31:0]             m_dat_o, s_dat_o;
  logic                    s_cyc, s_stb, s_we;
  logic [ADDR_W-1:0]       s_adr;
  logic [3:0]              s_sel;
  logic [2:0]              s_cti;
  logic [31:0]             s_dat_i = '0;
  logic                    s_ack = 1'b0;

  sdram_arbiter #(
    .NUM_M   (NUM_M),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TMO)
  ) dut (
    .wb_clk   (clk),
    .wb_rst_n (rst_n),
    .m_cyc    (m_cyc),
    .m_stb    (m_stb),
    .m_we     (m_we),
    .m_adr    (m_adr),
    .m_dat_i  (m_dat_i),
    .m_sel    (m_sel),
    .m_cti    (m_cti),
    .m_ack    (m_ack),
    .m_err    (m_err),
    .m_dat_o  (m_dat_o),
    .s_cyc    (s_cyc),
    .s_stb    (s_stb),
    .s_we     (s_we),
    .s_adr    (s_adr),
    .s_dat_o  (s_dat_o),
    .s_sel    (s_sel),
    .s_cti    (s_cti),
    .s_dat_i  (s_dat_i),
    .s_ack    (s_ack),
    .grant    (grant)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [23:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [2:0]  cti;
  } txn_t;

  typedef struct {
    int          m;
    bit          err;
    logic [31:0] dat;
    logic        we;
    logic [23:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [2:0]  cti;
  } exp_t;

  exp_t exp_q[$];
  txn_t cur[NUM_M];
  int   n_chk  = 0;
  int   n_pass = 0;
`ifdef SDRAM_ARB_RR_EN
  int   rr_last = NUM_M - 1;
`endif

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
  endfunction

  function automatic logic [NUM_M-1:0] oh(int i);
    return NUM_M'(1) << i;
  endfunction

  // Slave behaviour: ack arrives lat+1 cycles into BUSY, lat from adr[3:0].
  function automatic int lat_of(logic [23:0] a);
    return int'({28'd0, a[3:0]});
  endfunction

  function automatic logic [31:0] data_fn(logic [23:0] a, int b);
    return {8'hA0 + 8'(b), a};
  endfunction

  function automatic txn_t mk(logic we, logic [23:0] adr, logic [2:0] cti);
    txn_t t;
    t.we = we; t.adr = adr; t.cti = cti;
    t.wdat = $urandom; t.sel = 4'($urandom);
    return t;
  endfunction

  // Reference: service order is ascending index (fixed) or cyclic after last
  // owner (round-robin); an ack later than BUSY cycle TMO-1 becomes an abort.
  task automatic model_push(input logic [NUM_M-1:0] set, output int first);
    int order[$];
    int start = 0;
    exp_t e;
`ifdef SDRAM_ARB_RR_EN
    start = (rr_last + 1) % NUM_M;
`endif
    for (int k = 0; k < NUM_M; k++) begin
      int i = (start + k) % NUM_M;
      if (set[i]) order.push_back(i);
    end
    foreach (order[j]) begin
      txn_t t = cur[order[j]];
      e.m = order[j]; e.we = t.we; e.adr = t.adr; e.wdat = t.wdat;
      e.sel = t.sel; e.cti = t.cti; e.dat = '0;
      if (lat_of(t.adr) + 1 >= TMO) begin
        e.err = 1'b1;
        exp_q.push_back(e);
      end else begin
        e.err = 1'b0;
        for (int b = 0; b < ((t.cti == CTI_INCR) ? 2 : 1); b++) begin
          e.dat = data_fn(t.adr, b);
          exp_q.push_back(e);
        end
      end
    end
`ifdef SDRAM_ARB_RR_EN
    rr_last = order[$];
`endif
    first = order[0];
  endtask

  task automatic master_run(input int m, input txn_t t);
    int budget = 0;
    int done = 0;
    int nb = (t.cti == CTI_INCR) ? 2 : 1;
    bit err = 1'b0;
    m_we[m] = t.we;
    m_adr[m*ADDR_W +: ADDR_W] = t.adr;
    m_dat_i[m*32 +: 32] = t.wdat;
    m_sel[m*4 +: 4] = t.sel;
    m_cti[m*3 +: 3] = t.cti;
    m_cyc[m] = 1'b1;
    m_stb[m] = 1'b1;
    while (done < nb && !err && budget < 400) begin
      @(negedge clk);
      budget++;
      if (m_err[m]) err = 1'b1;
      else if (m_ack[m]) done++;
    end
    if (done < nb && !err) begin
      n_chk++;
      $display("FAIL master%0d_response_timeout: got %0d beats required %0d", m, done, nb);
    end
    @(posedge clk); #1;
    m_cyc[m] = 1'b0;
    m_stb[m] = 1'b0;
  endtask

  task automatic run_batch(input logic [NUM_M-1:0] set, input int ghost);
    int first;
    model_push(set, first);
    @(posedge clk); #1;
    for (int k = 0; k < NUM_M; k++) begin
      if (set[k]) begin
        automatic int   mm = k;
        automatic txn_t tt = cur[k];
        fork master_run(mm, tt); join_none
      end
    end
    if (ghost >= 0) begin
      fork
        begin
          repeat (3) @(posedge clk); #1;
          m_cyc[ghost] = 1'b1; m_stb[ghost] = 1'b1;
          repeat (2) @(posedge clk); #1;
          m_cyc[ghost] = 1'b0; m_stb[ghost] = 1'b0;
        end
      join_none
    end
    @(posedge clk); #1;
    chk("grant_latency", 64'(grant), 64'(oh(first)));
    wait fork;
    repeat (2) @(posedge clk);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_grant"}, 64'(grant), 64'(0));
    chk({tag, "_m_ack"}, 64'(m_ack), 64'(0));
    chk({tag, "_m_err"}, 64'(m_err), 64'(0));
    chk({tag, "_s_cyc_stb_we"}, 64'({s_cyc, s_stb, s_we}), 64'(0));
    chk({tag, "_s_adr"}, 64'(s_adr), 64'(0));
    chk({tag, "_s_dat_o"}, 64'(s_dat_o), 64'(0));
    chk({tag, "_s_sel_cti"}, 64'({s_sel, s_cti}), 64'(0));
  endtask

  // Behavioural SDRAM controller.
  initial begin : slave
    logic [23:0] a;
    int nb, guard;
    forever begin
      @(negedge clk);
      if (rst_n && s_cyc && s_stb) begin
        a  = s_adr;
        nb = (s_cti == CTI_INCR) ? 2 : 1;
        repeat (lat_of(a) + 1) @(posedge clk);
        #1;
        if (s_cyc) begin
          for (int b = 0; b < nb; b++) begin
            s_ack = 1'b1;
            s_dat_i = data_fn(a, b);
            @(posedge clk); #1;
          end
        end
        s_ack = 1'b0;
        s_dat_i = $urandom;
        guard = 0;
        while (s_cyc && guard < 500) begin
          @(negedge clk);
          guard++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every ack/err and tracks grant handover.
  logic [NUM_M-1:0] prev_grant = '0;
  int   since = 0;
  bit   regrant_due = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (!rst_n) begin
      since = 0;
      regrant_due = 1'b0;
    end else begin
      if (grant != 0 && prev_grant == 0) begin
        since = 0;
        chk("grant_onehot", 64'($onehot(grant)), 64'(1));
      end else if (grant != 0) begin
        since++;
      end
      if (regrant_due) begin
        chk("regrant_after_one_dead_cycle", 64'(grant != 0), 64'(1));
        regrant_due = 1'b0;
      end
      if (prev_grant != 0 && grant == 0 && (m_cyc & m_stb) != 0) regrant_due = 1'b1;
      if (|m_ack || |m_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_response", 64'({m_err, m_ack}), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("resp_master", 64'(m_ack | m_err), 64'(oh(e.m)));
          chk("resp_is_err", 64'(m_err != 0), 64'(e.err));
          chk("resp_grant", 64'(grant), 64'(oh(e.m)));
          if (e.err) begin
            chk("abort_busy_cycles", 64'(since), 64'(TMO));
            chk("abort_s_cyc_low", 64'({s_cyc, s_stb}), 64'(0));
          end else begin
            chk("rd_data", 64'(m_dat_o), 64'(e.dat));
            chk("s_adr_mux", 64'(s_adr), 64'(e.adr));
            chk("s_wdat_mux", 64'(s_dat_o), 64'(e.wdat));
            chk("s_we_sel_cti_mux", 64'({s_we, s_sel, s_cti}), 64'({e.we, e.sel, e.cti}));
          end
        end
      end
    end
    prev_grant = grant;
  end

  initial begin : stim
    #12;
    check_zero("reset");
    #10 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    cur[2] = mk(1'b0, 24'h123405, 3'b000);
    run_batch(3'b100, -1);

    cur[0] = mk(1'b0, 24'h00AB03, CTI_INCR);
    run_batch(3'b001, -1);

    cur[0] = mk(1'b1, 24'h111102, 3'b000);
    cur[1] = mk(1'b0, 24'h222206, CTI_INCR);
    cur[2] = mk(1'b1, 24'h333301, 3'b000);
    run_batch(3'b111, -1);

    cur[1] = mk(1'b1, 24'h000F0F, 3'b000);
    cur[2] = mk(1'b0, 24'h444402, 3'b000);
    run_batch(3'b110, -1);

    cur[0] = mk(1'b0, 24'h55550E, CTI_INCR);
    run_batch(3'b001, -1);

    cur[0] = mk(1'b0, 24'h66660A, 3'b000);
    run_batch(3'b001, 1);

    // Reset asserted between the two beats of a burst.
    cur[0] = mk(1'b0, 24'h005502, CTI_INCR);
    @(posedge clk); #1;
    m_adr[0 +: ADDR_W] = cur[0].adr;
    m_cti[0 +: 3] = cur[0].cti;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(posedge clk); #1;
    chk("rst_pre_grant", 64'(grant), 64'(3'b001));
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero("rst_mid");
    m_cyc = '0; m_stb = '0;
`ifdef SDRAM_ARB_RR_EN
    rr_last = NUM_M - 1;
`endif
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(posedge clk);

    cur[1] = mk(1'b1, 24'h777703, 3'b000);
    run_batch(3'b010, -1);

    for (int n = 0; n < 40; n++) begin
      logic [NUM_M-1:0] set = NUM_M'($urandom_range(1, 7));
      for (int k = 0; k < NUM_M; k++) begin
        logic [2:0] c;
        case ($urandom_range(0, 2))
          0:       c = CTI_INCR;
          1:       c = 3'b000;
          default: c = 3'b111;
        endcase
        cur[k] = mk(1'($urandom), 24'($urandom), c);
      end
      run_batch(set, -1);
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
